// File: rtl/fwrisc_fetch_pf.sv
// fwrisc_fetch_pf -- prefetching instruction-fetch unit.
// Keeps a circular buffer of HW_DEPTH halfwords filled from the word-aligned
// instruction bus. It presents one 16-bit (RVC) or 32-bit instruction per decode
// handshake. Unaligned 32-bit instructions are joined across bus words, and
// sequential flow never refetches.
// Optional build macro FWRISC_FETCH_PC_EN adds the instr_pc output, which gives the
// byte address of the instruction currently presented.
module fwrisc_fetch_pf #(
  parameter int unsigned ENABLE_COMPRESSED = 1,
  parameter int unsigned HW_DEPTH          = 8,
  parameter logic [31:0] RESET_VECTOR      = 32'h8000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        fetch_en,
  input  logic        redirect,
  input  logic [31:1] redirect_pc,
  output logic [31:0] iaddr,
  input  logic [31:0] idata,
  output logic        ivalid,
  input  logic        iready,
  output logic        fetch_valid,
  input  logic        decode_ready,
  output logic [31:0] instr,
  output logic        instr_c
`ifdef FWRISC_FETCH_PC_EN
  ,
  output logic [31:0] instr_pc
`endif
);

  // Pointer width and occupancy width (occupancy must be able to hold HW_DEPTH itself).
  localparam int PW = $clog2(HW_DEPTH);
  localparam int CW = PW + 1;

  // A new word can only be requested while two free halfword slots remain.
  localparam logic [CW-1:0] FETCH_LIMIT = CW'(HW_DEPTH - 2);
  localparam logic [CW-1:0] ONE_HW      = CW'(1);
  localparam logic [CW-1:0] TWO_HW      = CW'(2);

  // Fetch address is kept as a word address; the low two bits are always zero.
  logic [31:2]   fetch_addr_reg, fetch_addr_next;
  // After a redirect to an odd halfword, the low half of the first word is discarded.
  logic          skip_lo_reg, skip_lo_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0] count_reg, count_next;

  // Halfword storage and head-of-buffer view.
  logic [15:0]   entries [HW_DEPTH];
  logic [PW-1:0] wr_ptr_plus1;
  logic [PW-1:0] rd_ptr_plus1;
  logic [15:0]   h0;
  logic [15:0]   h1;
  logic          h0_is_c;
  logic          head_ready;

  // Handshakes and per-cycle occupancy deltas.
  logic          accept;
  logic          pop;
  logic [CW-1:0] push_cnt;
  logic [CW-1:0] pop_cnt;

  assign wr_ptr_plus1 = wr_ptr_reg + PW'(1);
  assign rd_ptr_plus1 = rd_ptr_reg + PW'(1);

  // ---------------------------------------------------------------------------
  // Bus request side
  // ---------------------------------------------------------------------------
  // Requests are suppressed during reset, during a redirect cycle, and when full.
  assign ivalid = reset_n && fetch_en && !redirect && (count_reg <= FETCH_LIMIT);
  assign iaddr  = {fetch_addr_reg, 2'b00};
  assign accept = ivalid && iready;

  // ---------------------------------------------------------------------------
  // Decode side
  // ---------------------------------------------------------------------------
  assign h0 = entries[rd_ptr_reg];
  assign h1 = entries[rd_ptr_plus1];

  // Any halfword whose low two bits are not 2'b11 starts an RVC instruction.
  assign h0_is_c = (ENABLE_COMPRESSED != 0) && (h0[1:0] != 2'b11);

  // A 32-bit instruction waits until both of its halves are buffered.
  assign head_ready = h0_is_c ? (count_reg >= ONE_HW) : (count_reg >= TWO_HW);

  assign fetch_valid = !redirect && head_ready;
  assign pop         = fetch_valid && decode_ready;

  // Present the head instruction, forced to zero whenever nothing is valid.
  always_comb begin
    instr   = 32'h0;
    instr_c = 1'b0;
    if (fetch_valid) begin
      if (h0_is_c) begin
        instr   = {16'h0, h0};
        instr_c = 1'b1;
      end else begin
        instr   = {h1, h0};
        instr_c = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Buffer storage: each slot captures the low or high half of an accepted word
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < HW_DEPTH; gi++) begin : g_slot
      logic        wr_first;
      logic        wr_second;
      logic [15:0] slot_reg;

      // The first halfword pushed goes to wr_ptr; the second goes to wr_ptr+1.
      assign wr_first  = accept && (wr_ptr_reg == PW'(gi));
      assign wr_second = accept && !skip_lo_reg && (wr_ptr_plus1 == PW'(gi));

      // Data slots need no reset: occupancy alone decides what is meaningful.
      always_ff @(posedge clock) begin
        if (wr_first) begin
          slot_reg <= skip_lo_reg ? idata[31:16] : idata[15:0];
        end else if (wr_second) begin
          slot_reg <= idata[31:16];
        end
      end

      assign entries[gi] = slot_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Pointer, occupancy and fetch-address update
  // ---------------------------------------------------------------------------
  // Compute how many halfwords enter and leave the buffer this cycle.
  always_comb begin
    push_cnt = '0;
    pop_cnt  = '0;
    if (accept) begin
      push_cnt = skip_lo_reg ? ONE_HW : TWO_HW;
    end
    if (pop) begin
      pop_cnt = instr_c ? ONE_HW : TWO_HW;
    end
  end

  // A redirect flushes everything and wins over a same-cycle pop.
  always_comb begin
    fetch_addr_next = fetch_addr_reg;
    skip_lo_next    = skip_lo_reg;
    rd_ptr_next     = rd_ptr_reg;
    wr_ptr_next     = wr_ptr_reg;
    count_next      = count_reg;
    if (redirect) begin
      fetch_addr_next = redirect_pc[31:2];
      skip_lo_next    = (ENABLE_COMPRESSED != 0) && redirect_pc[1];
      rd_ptr_next     = wr_ptr_reg;
      count_next      = '0;
    end else begin
      wr_ptr_next = wr_ptr_reg + PW'(push_cnt);
      rd_ptr_next = rd_ptr_reg + PW'(pop_cnt);
      count_next  = count_reg + push_cnt - pop_cnt;
      if (accept) begin
        fetch_addr_next = fetch_addr_reg + 30'd1;
        skip_lo_next    = 1'b0;
      end
    end
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_addr_reg <= RESET_VECTOR[31:2];
      skip_lo_reg    <= 1'b0;
      rd_ptr_reg     <= '0;
      wr_ptr_reg     <= '0;
      count_reg      <= '0;
    end else begin
      fetch_addr_reg <= fetch_addr_next;
      skip_lo_reg    <= skip_lo_next;
      rd_ptr_reg     <= rd_ptr_next;
      wr_ptr_reg     <= wr_ptr_next;
      count_reg      <= count_next;
    end
  end

`ifdef FWRISC_FETCH_PC_EN
  // ---------------------------------------------------------------------------
  // Program counter of the instruction at the buffer head
  // ---------------------------------------------------------------------------
  logic [31:0] head_pc_reg, head_pc_next;

  // Follow redirects exactly, and otherwise advance by the size of each popped instruction.
  always_comb begin
    head_pc_next = head_pc_reg;
    if (redirect) begin
      head_pc_next = {redirect_pc, 1'b0};
    end else if (pop) begin
      head_pc_next = head_pc_reg + (instr_c ? 32'd2 : 32'd4);
    end
  end

  // Head PC register, which restarts at the reset vector.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_pc_reg <= RESET_VECTOR;
    end else begin
      head_pc_reg <= head_pc_next;
    end
  end

  assign instr_pc = fetch_valid ? head_pc_reg : 32'h0;
`endif

endmodule

// File: tb/tb_fwrisc_fetch_pf.sv
// tb_fwrisc_fetch_pf -- directed bench for the prefetching fetch unit.
// Two instances share all control inputs. Instance 0 has RVC enabled and
// instance 1 has RVC disabled. A program-order model checks both every cycle.
module tb_fwrisc_fetch_pf;

  localparam logic [31:0] RV    = 32'h8000_0000;
  localparam int          DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        fetch_en;
  logic        redirect;
  logic [31:1] redirect_pc;
  logic        iready;
  logic        decode_ready;

  logic [31:0] iaddr_w       [2];
  logic [31:0] idata_w       [2];
  logic        ivalid_w      [2];
  logic        fetch_valid_w [2];
  logic [31:0] instr_w       [2];
  logic        instr_c_w     [2];
`ifdef FWRISC_FETCH_PC_EN
  logic [31:0] instr_pc_w    [2];
`endif

  // Instruction memory covering 0x80000000..0x800001FF (aliased elsewhere).
  logic [31:0] mem [128];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  assign idata_w[0] = mem[iaddr_w[0][8:2]];
  assign idata_w[1] = mem[iaddr_w[1][8:2]];

  fwrisc_fetch_pf #(.ENABLE_COMPRESSED(1), .HW_DEPTH(DEPTH), .RESET_VECTOR(RV)) u_dut_c (
    .clock(clock), .reset_n(reset_n), .fetch_en(fetch_en), .redirect(redirect),
    .redirect_pc(redirect_pc), .iaddr(iaddr_w[0]), .idata(idata_w[0]), .ivalid(ivalid_w[0]),
    .iready(iready), .fetch_valid(fetch_valid_w[0]), .decode_ready(decode_ready),
    .instr(instr_w[0]), .instr_c(instr_c_w[0])
`ifdef FWRISC_FETCH_PC_EN
    , .instr_pc(instr_pc_w[0])
`endif
  );

  fwrisc_fetch_pf #(.ENABLE_COMPRESSED(0), .HW_DEPTH(DEPTH), .RESET_VECTOR(RV)) u_dut_nc (
    .clock(clock), .reset_n(reset_n), .fetch_en(fetch_en), .redirect(redirect),
    .redirect_pc(redirect_pc), .iaddr(iaddr_w[1]), .idata(idata_w[1]), .ivalid(ivalid_w[1]),
    .iready(iready), .fetch_valid(fetch_valid_w[1]), .decode_ready(decode_ready),
    .instr(instr_w[1]), .instr_c(instr_c_w[1])
`ifdef FWRISC_FETCH_PC_EN
    , .instr_pc(instr_pc_w[1])
`endif
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %08h expected %08h", name, $time, act, exp);
    end
  endtask

  function automatic logic [15:0] hw(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[8:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Program-order model. mpc is the address of the next instruction that decode
  // should see. mfa is the next word address to be fetched. The halfwords held
  // in the buffer are exactly those from mpc up to mfa.
  // ---------------------------------------------------------------------------
  logic [31:0] mpc [2];
  logic [31:0] mfa [2];
  int          m_cnt;
  logic [15:0] m_h0;
  logic        m_comp, m_iv, m_fv, m_c;
  logic [31:0] m_instr, m_tgt;

  always @(negedge clock) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset_n) begin
        mpc[k] = RV;
        mfa[k] = RV;
        check32($sformatf("rst_ivalid[%0d]", k), 32'(ivalid_w[k]), 32'd0);
        check32($sformatf("rst_fetch_valid[%0d]", k), 32'(fetch_valid_w[k]), 32'd0);
        check32($sformatf("rst_instr[%0d]", k), instr_w[k], 32'd0);
        check32($sformatf("rst_instr_c[%0d]", k), 32'(instr_c_w[k]), 32'd0);
      end else begin
        m_cnt = $signed(mfa[k] - mpc[k]);
        m_cnt = m_cnt / 2;
        if (m_cnt < 0) m_cnt = 0;
        m_h0    = hw(mpc[k]);
        m_comp  = (k == 0) && (m_h0[1:0] != 2'b11);
        m_iv    = fetch_en && !redirect && (m_cnt <= DEPTH - 2);
        m_fv    = !redirect && (m_comp ? (m_cnt >= 1) : (m_cnt >= 2));
        m_c     = m_fv && m_comp;
        m_instr = !m_fv ? 32'h0 : (m_comp ? {16'h0, m_h0} : {hw(mpc[k] + 32'd2), m_h0});
        check32($sformatf("ivalid[%0d]", k), 32'(ivalid_w[k]), 32'(m_iv));
        if (m_iv) check32($sformatf("iaddr[%0d]", k), iaddr_w[k], mfa[k]);
        check32($sformatf("fetch_valid[%0d]", k), 32'(fetch_valid_w[k]), 32'(m_fv));
        check32($sformatf("instr[%0d]", k), instr_w[k], m_instr);
        check32($sformatf("instr_c[%0d]", k), 32'(instr_c_w[k]), 32'(m_c));
`ifdef FWRISC_FETCH_PC_EN
        if (k == 0) check32("instr_pc[0]", instr_pc_w[0], m_fv ? mpc[0] : 32'h0);
`endif
        // Advance the model for the coming clock edge.
        if (redirect) begin
          m_tgt  = {redirect_pc, 1'b0};
          mfa[k] = {m_tgt[31:2], 2'b00};
          mpc[k] = (k == 0) ? m_tgt : {m_tgt[31:2], 2'b00};
        end else begin
          if (m_iv && iready) mfa[k] = mfa[k] + 32'd4;
          if (m_fv && decode_ready) mpc[k] = mpc[k] + (m_comp ? 32'd2 : 32'd4);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_valid(input int k, input string name);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge clock);
      if (fetch_valid_w[k]) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s: fetch_valid[%0d] never rose within 60 cycles", name, k);
    end
  endtask

  task automatic wait_ivalid(input int k, input string name);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge clock);
      if (ivalid_w[k]) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s: ivalid[%0d] never rose within 60 cycles", name, k);
    end
  endtask

  task automatic expect_instr(input int k, input logic [31:0] ei, input logic ec, input string name);
    wait_valid(k, name);
    check32({name, "_instr"}, instr_w[k], ei);
    check32({name, "_c"}, 32'(instr_c_w[k]), 32'(ec));
    $display("txn %s: inst%0d instr=%08h c=%0d", name, k, instr_w[k], instr_c_w[k]);
  endtask

  task automatic do_redirect(input logic [31:0] tgt, input logic dr);
    tick();
    redirect     = 1'b1;
    redirect_pc  = tgt[31:1];
    decode_ready = dr;
    @(negedge clock);
    check32("redir_fetch_valid", 32'(fetch_valid_w[0]), 32'd0);
    check32("redir_ivalid", 32'(ivalid_w[0]), 32'd0);
    tick();
    redirect = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    reset_n      = 1'b1;
    fetch_en     = 1'b1;
    redirect     = 1'b0;
    redirect_pc  = '0;
    iready       = 1'b1;
    decode_ready = 1'b1;
    clear_mem();
    mem[0] = 32'h0000_0013;
    mem[1] = 32'h0010_0093;
    #1 reset_n = 1'b0;

    // Reset state, with fetch_en already high.
    @(negedge clock);
    check32("reset_ivalid", 32'(ivalid_w[0]), 32'd0);
    check32("reset_instr", instr_w[0], 32'd0);

    // Two aligned 32-bit instructions.
    tick();
    reset_n = 1'b1;
    wait_ivalid(0, "t1_req0");
    check32("t1_iaddr0", iaddr_w[0], 32'h8000_0000);
    expect_instr(0, 32'h0000_0013, 1'b0, "t1_i0");
    check32("t1_iaddr1", iaddr_w[0], 32'h8000_0004);
    expect_instr(0, 32'h0010_0093, 1'b0, "t1_i1");

    // Compressed instructions, and a 32-bit instruction split across words.
    tick();
    reset_n = 1'b0;
    clear_mem();
    mem[0]  = 32'h0085_4501;
    mem[1]  = 32'h0093_4501;
    mem[2]  = 32'h4141_0023;
    mem[3]  = 32'h0010_0093;
    mem[64] = 32'h0093_1111;
    mem[65] = 32'h8082_0023;
    mem[66] = 32'h0000_0013;
    tick();
    tick();
    reset_n = 1'b1;
    expect_instr(0, 32'h0000_4501, 1'b1, "t2_i0");
    expect_instr(0, 32'h0000_0085, 1'b1, "t2_i1");
    expect_instr(0, 32'h0000_4501, 1'b1, "t2_i2");
    expect_instr(0, 32'h0023_0093, 1'b0, "t2_i3");
    expect_instr(0, 32'h0000_4141, 1'b1, "t2_i4");
    expect_instr(0, 32'h0010_0093, 1'b0, "t2_i5");

    // Redirect to an odd halfword: the low half of the first word is skipped.
    do_redirect(32'h8000_0102, 1'b1);
    wait_ivalid(0, "t3_req");
    check32("t3_iaddr", iaddr_w[0], 32'h8000_0100);
    expect_instr(0, 32'h0023_0093, 1'b0, "t3_i0");
`ifdef FWRISC_FETCH_PC_EN
    check32("t3_pc0", instr_pc_w[0], 32'h8000_0102);
`endif
    expect_instr(0, 32'h0000_8082, 1'b1, "t3_i1");
`ifdef FWRISC_FETCH_PC_EN
    check32("t3_pc1", instr_pc_w[0], 32'h8000_0106);
`endif
    expect_instr(0, 32'h0000_0013, 1'b0, "t3_i2");

    // Backpressure fills the buffer, then it drains in order with fetch_en low.
    do_redirect(32'h8000_0000, 1'b0);
    repeat (12) tick();
    @(negedge clock);
    check32("t4_full_ivalid", 32'(ivalid_w[0]), 32'd0);
    check32("t4_full_valid", 32'(fetch_valid_w[0]), 32'd1);
    check32("t4_full_instr", instr_w[0], 32'h0000_4501);
    tick();
    decode_ready = 1'b1;
    fetch_en     = 1'b0;
    expect_instr(0, 32'h0000_4501, 1'b1, "t4_i0");
    expect_instr(0, 32'h0000_0085, 1'b1, "t4_i1");
    expect_instr(0, 32'h0000_4501, 1'b1, "t4_i2");
    expect_instr(0, 32'h0023_0093, 1'b0, "t4_i3");
    expect_instr(0, 32'h0000_4141, 1'b1, "t4_i4");
    expect_instr(0, 32'h0010_0093, 1'b0, "t4_i5");
    repeat (4) tick();
    @(negedge clock);
    check32("t4_empty_valid", 32'(fetch_valid_w[0]), 32'd0);
    check32("t4_empty_ivalid", 32'(ivalid_w[0]), 32'd0);

    // Redirect while an instruction is ready and decode is ready: no pop, old data flushed.
    tick();
    fetch_en     = 1'b1;
    decode_ready = 1'b0;
    repeat (6) tick();
    do_redirect(32'h8000_0100, 1'b1);
    expect_instr(0, 32'h0000_1111, 1'b1, "t5_i0");
    expect_instr(0, 32'h0023_0093, 1'b0, "t5_i1");
    expect_instr(0, 32'h0000_8082, 1'b1, "t5_i2");

    // RVC disabled instance: compressed encodings are treated as 32-bit; reset mid-fetch.
    tick();
    reset_n = 1'b0;
    clear_mem();
    mem[0] = 32'h0000_4501;
    mem[1] = 32'h0010_0093;
    tick();
    tick();
    reset_n = 1'b1;
    expect_instr(1, 32'h0000_4501, 1'b0, "t6_i0");
    wait_ivalid(1, "t6_busy");
    tick();
    reset_n = 1'b0;
    #1;
    check32("t6_rst_ivalid", 32'(ivalid_w[1]), 32'd0);
    tick();
    reset_n = 1'b1;
    wait_ivalid(1, "t6_refetch");
    check32("t6_iaddr", iaddr_w[1], 32'h8000_0000);
    expect_instr(1, 32'h0000_4501, 1'b0, "t6_i1");

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
